// File: rtl/win_screen_ctrl.sv
// Winner banner controller: latches the winner, sequences reveal/blink/show,
// maps scan coordinates into banner space and colour-keys ROM pixels over the game layer.
module win_screen_ctrl #(
    parameter int          IMG_W         = 150,
    parameter int          IMG_H         = 100,
    parameter int          X0            = 245,
    parameter int          Y0            = 190,
    parameter logic [11:0] KEY_CLR       = 12'hF0F,
    parameter int          BLINK_FRAMES  = 16,
    parameter int          REVEAL_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_over,
    input  logic        winner_in,
    input  logic        restart,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic [9:0]  vga_x,
    input  logic [8:0]  vga_y,
    input  logic [11:0] game_clr,
    output logic [9:0]  img_x,
    output logic [8:0]  img_y,
    output logic        winner_id,
    input  logic [11:0] rom_clr,
    output logic [11:0] pix_clr,
    output logic        active
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REVEAL = 2'd1;
    localparam logic [1:0] S_SHOW   = 2'd2;

    localparam int FW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(REVEAL_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + IMG_W - 1);
    localparam logic [8:0] Y_LO = 9'(Y0);
    localparam logic [8:0] Y_HI = 9'(Y0 + IMG_H - 1);

    logic [1:0]    r_state;
    logic [FW-1:0] r_frame_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic          r_winner;
    logic          r_active;

    logic [9:0]    r_img_x;
    logic [8:0]    r_img_y;
    logic          r_vis1, r_vid1, r_vis2, r_vid2;
    logic [11:0]   r_gclr1, r_gclr2, r_pix_clr;

    logic          w_in_win;

    // NOTE: every state bit uses <= so all registers sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_winner    <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (game_over) begin
                        r_state     <= S_REVEAL;
                        r_winner    <= winner_in;
                        r_frame_cnt <= '0;
                        r_blink_cnt <= '0;
                        r_blink_on  <= 1'b1;
                        r_active    <= 1'b1;
                    end
                end
                S_REVEAL: begin
                    if (restart) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end else if (frame_tick) begin
                        if (r_frame_cnt == FRAME_LAST) begin
                            r_state    <= S_SHOW;
                            r_blink_on <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            if (r_blink_cnt == BLINK_LAST) begin
                                r_blink_cnt <= '0;
                                r_blink_on  <= ~r_blink_on;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_SHOW: begin
                    r_blink_on <= 1'b1;
                    if (restart) begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign w_in_win = video_on && (vga_x >= X_LO) && (vga_x <= X_HI)
                   && (vga_y >= Y_LO) && (vga_y <= Y_HI);

    // Subtraction is only selected inside the window, so it never underflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_img_x   <= '0;
            r_img_y   <= '0;
            r_vis1    <= 1'b0;
            r_vid1    <= 1'b0;
            r_gclr1   <= '0;
            r_vis2    <= 1'b0;
            r_vid2    <= 1'b0;
            r_gclr2   <= '0;
            r_pix_clr <= '0;
        end else begin
            r_img_x <= w_in_win ? (vga_x - X_LO) : 10'd0;
            r_img_y <= w_in_win ? (vga_y - Y_LO) : 9'd0;
            r_vis1  <= w_in_win && r_active && r_blink_on;
            r_vid1  <= video_on;
            r_gclr1 <= game_clr;

            r_vis2  <= r_vis1;
            r_vid2  <= r_vid1;
            r_gclr2 <= r_gclr1;

            if (!r_vid2)
                r_pix_clr <= 12'h000;
            else if (r_vis2 && (rom_clr != KEY_CLR))
                r_pix_clr <= rom_clr;
            else
                r_pix_clr <= r_gclr2;
        end
    end

    assign img_x     = r_img_x;
    assign img_y     = r_img_y;
    assign winner_id = r_winner;
    assign pix_clr   = r_pix_clr;
    assign active    = r_active;

endmodule

// File: tb/tb_win_screen_ctrl.sv
// Self-checking bench for win_screen_ctrl: directed boundary scans plus randomized
// pixel streams compared against a window/blink reference model.
module tb_win_screen_ctrl;

    localparam int          W   = 150;
    localparam int          H   = 100;
    localparam int          X0  = 245;
    localparam int          Y0  = 190;
    localparam logic [11:0] KEY = 12'hF0F;
    localparam int          BF  = 2;
    localparam int          RF  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_over, winner_in, restart, frame_tick, video_on;
    logic [9:0]  vga_x;
    logic [8:0]  vga_y;
    logic [11:0] game_clr, rom_clr;
    logic [9:0]  img_x;
    logic [8:0]  img_y;
    logic        winner_id, active;
    logic [11:0] pix_clr;

    int checks   = 0;
    int failures = 0;

    win_screen_ctrl #(
        .IMG_W(W), .IMG_H(H), .X0(X0), .Y0(Y0), .KEY_CLR(KEY),
        .BLINK_FRAMES(BF), .REVEAL_FRAMES(RF)
    ) dut (
        .clk(clk), .rst(rst), .game_over(game_over), .winner_in(winner_in),
        .restart(restart), .frame_tick(frame_tick), .video_on(video_on),
        .vga_x(vga_x), .vga_y(vga_y), .game_clr(game_clr),
        .img_x(img_x), .img_y(img_y), .winner_id(winner_id),
        .rom_clr(rom_clr), .pix_clr(pix_clr), .active(active)
    );

    always #5 clk = ~clk;

    // Reference model: banner rectangle, local coordinates and colour-key compositing.
    function automatic bit m_in_win(input int x, input int y, input bit vid);
        return vid && (x >= X0) && (x < X0 + W) && (y >= Y0) && (y < Y0 + H);
    endfunction

    function automatic int m_img_x(input int x, input int y, input bit vid);
        return m_in_win(x, y, vid) ? x - X0 : 0;
    endfunction

    function automatic int m_img_y(input int x, input int y, input bit vid);
        return m_in_win(x, y, vid) ? y - Y0 : 0;
    endfunction

    function automatic logic [11:0] m_pix(input int x, input int y, input bit vid,
                                          input logic [11:0] g, input logic [11:0] r,
                                          input bit shown);
        if (!vid) return 12'h000;
        if (shown && m_in_win(x, y, vid) && r != KEY) return r;
        return g;
    endfunction

    // Banner visibility after a given number of reveal ticks.
    function automatic bit m_shown(input int ticks);
        return (ticks >= RF) || (((ticks / BF) % 2) == 0);
    endfunction

    task automatic pulse_tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic scan(input string nm, input int x, input int y, input bit vid,
                        input logic [11:0] g, input logic [11:0] r, input bit shown);
        int          ex, ey;
        logic [11:0] ep;
        ex = m_img_x(x, y, vid);
        ey = m_img_y(x, y, vid);
        ep = m_pix(x, y, vid, g, r, shown);
        @(negedge clk);
        vga_x = 10'(x); vga_y = 9'(y); video_on = vid; game_clr = g;
        @(negedge clk);
        rom_clr = r;
        checks++;
        if (int'(img_x) !== ex || int'(img_y) !== ey) begin
            failures++;
            $display("FAIL %s img at (%0d,%0d): got (%0d,%0d) want (%0d,%0d)",
                     nm, x, y, img_x, img_y, ex, ey);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pix_clr !== ep) begin
            failures++;
            $display("FAIL %s pix at (%0d,%0d): got %h want %h", nm, x, y, pix_clr, ep);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; game_over = 0; winner_in = 0; restart = 0; frame_tick = 0;
        video_on = 0; vga_x = 0; vga_y = 0; game_clr = 0; rom_clr = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({img_x, img_y, winner_id, pix_clr, active} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got img=(%0d,%0d) win=%b pix=%h act=%b want all 0",
                     img_x, img_y, winner_id, pix_clr, active);
        end
        rst = 1'b0;
        scan("idle_scan", 300, 200, 1'b1, 12'h123, 12'hABC, 1'b0);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL idle_active: got %b want 0", active);
        end
    endtask

    task automatic test_enter();
        @(negedge clk); game_over = 1'b1; winner_in = 1'b1;
        @(negedge clk); game_over = 1'b0; winner_in = 1'b0;
        checks++;
        if (active !== 1'b1 || winner_id !== 1'b1) begin
            failures++;
            $display("FAIL enter: got active=%b winner=%b want 1/1", active, winner_id);
        end
        scan("corner_tl", 245, 190, 1'b1, 12'h321, 12'h0F0, 1'b1);
        scan("corner_br", 394, 289, 1'b1, 12'h321, 12'h0F0, 1'b1);
        scan("right_out", 395, 289, 1'b1, 12'h456, 12'h0F0, 1'b1);
        scan("left_out",  244, 190, 1'b1, 12'h789, 12'h0F0, 1'b1);
    endtask

    task automatic test_blink();
        for (int t = 0; t < 12; t++) begin
            if (t > 0) pulse_tick();
            scan($sformatf("blink_t%0d", t), 320, 240, 1'b1, 12'h111, 12'hABC, m_shown(t));
            checks++;
            if (active !== 1'b1) begin
                failures++;
                $display("FAIL blink_active t=%0d: got %b want 1", t, active);
            end
        end
    endtask

    task automatic test_show_composite();
        scan("key_transparent", 300, 250, 1'b1, 12'h246, KEY,     1'b1);
        scan("rom_opaque",      300, 250, 1'b1, 12'h246, 12'hABC, 1'b1);
        scan("video_off",       300, 250, 1'b0, 12'h246, 12'hABC, 1'b1);
    endtask

    task automatic test_stream(input string nm, input int n, input bit shown);
        int          xs[256], ys[256];
        bit          vs[256];
        logic [11:0] gs[256], rs[256], ep;
        for (int i = 0; i < n; i++) begin
            xs[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 639)
                                                : $urandom_range(X0 - 3, X0 + W + 2);
            ys[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 479)
                                                : $urandom_range(Y0 - 3, Y0 + H + 2);
            vs[i] = ($urandom_range(0, 9) != 0);
            gs[i] = 12'($urandom);
            rs[i] = ($urandom_range(0, 2) == 0) ? KEY : 12'($urandom);
        end
        for (int m = 0; m < n + 3; m++) begin
            @(negedge clk);
            if (m >= 1 && m - 1 < n) begin
                checks++;
                if (int'(img_x) !== m_img_x(xs[m-1], ys[m-1], vs[m-1]) ||
                    int'(img_y) !== m_img_y(xs[m-1], ys[m-1], vs[m-1])) begin
                    failures++;
                    $display("FAIL %s img #%0d: got (%0d,%0d) want (%0d,%0d)", nm, m - 1,
                             img_x, img_y, m_img_x(xs[m-1], ys[m-1], vs[m-1]),
                             m_img_y(xs[m-1], ys[m-1], vs[m-1]));
                end
            end
            if (m >= 3) begin
                ep = m_pix(xs[m-3], ys[m-3], vs[m-3], gs[m-3], rs[m-3], shown);
                checks++;
                if (pix_clr !== ep) begin
                    failures++;
                    $display("FAIL %s pix #%0d: got %h want %h", nm, m - 3, pix_clr, ep);
                end
            end
            if (m < n) begin
                vga_x = 10'(xs[m]); vga_y = 9'(ys[m]); video_on = vs[m]; game_clr = gs[m];
            end else begin
                video_on = 1'b0;
            end
            if (m >= 2 && m - 2 < n) rom_clr = rs[m-2];
        end
    endtask

    task automatic test_winner_hold();
        @(negedge clk); game_over = 1'b1; winner_in = 1'b0;
        @(negedge clk); game_over = 1'b0;
        checks++;
        if (winner_id !== 1'b1 || active !== 1'b1) begin
            failures++;
            $display("FAIL show_gameover_ignored: got winner=%b active=%b want 1/1",
                     winner_id, active);
        end
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL restart_idle: got active=%b want 0", active);
        end
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL idle_restart_ignored: got active=%b want 0", active);
        end
        test_stream("idle_stream", 60, 1'b0);
        @(negedge clk); game_over = 1'b1; winner_in = 1'b0;
        @(negedge clk); game_over = 1'b0;
        checks++;
        if (winner_id !== 1'b0 || active !== 1'b1) begin
            failures++;
            $display("FAIL relatch_winner: got winner=%b active=%b want 0/1", winner_id, active);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0; game_over = 1'b1; winner_in = 1'b1;
        @(negedge clk); game_over = 1'b0; winner_in = 1'b0;
        pulse_tick();
        @(negedge clk);
        vga_x = 10'd300; vga_y = 9'd230; video_on = 1'b1; game_clr = 12'h5A5; rom_clr = 12'hABC;
        repeat (4) @(negedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        checks++;
        if ({img_x, img_y, winner_id, pix_clr, active} !== '0) begin
            failures++;
            $display("FAIL async_reset: got img=(%0d,%0d) win=%b pix=%h act=%b want all 0",
                     img_x, img_y, winner_id, pix_clr, active);
        end
        @(negedge clk); rst = 1'b0;
        game_over = 1'b1; restart = 1'b1; winner_in = 1'b1;
        @(negedge clk); game_over = 1'b0; restart = 1'b0; winner_in = 1'b0;
        checks++;
        if (active !== 1'b1 || winner_id !== 1'b1) begin
            failures++;
            $display("FAIL idle_go_restart: got active=%b winner=%b want 1/1", active, winner_id);
        end
        scan("post_reset_reveal", 320, 240, 1'b1, 12'h111, 12'h0AB, 1'b1);
    endtask

    initial begin
        test_reset();
        test_enter();
        test_blink();
        test_show_composite();
        test_stream("show_stream", 200, 1'b1);
        test_winner_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/win_screen_ctrl.md
Name: win_screen_ctrl

Overview:
- Upstream and downstream companion of the win-image ROM block; it owns when and where the winner banner appears.
- Latches the winner on game over and runs a reveal/blink/show state machine.
- Converts VGA scan coordinates into image-local x/y for the ROM block, then composites the returned ROM colour over the game picture with a transparent colour key.
- Sits between the VGA timing generator/game renderer and the VGA output register.

Parameters:
- IMG_W, 150, banner width in pixels (ROM row stride)
- IMG_H, 100, banner height in pixels
- X0, 245, screen column of banner left edge
- Y0, 190, screen row of banner top edge
- KEY_CLR, 12'hF0F, ROM colour treated as transparent
- BLINK_FRAMES, 16, frames per blink half-period during reveal
- REVEAL_FRAMES, 128, total reveal duration in frames

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- game_over  in  1  one-cycle pulse, game ended
- winner_in  in  1  winning player index, valid with game_over
- restart  in  1  one-cycle pulse, leave win screen
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- video_on  in  1  current coordinate is visible
- vga_x  in  10  current screen column
- vga_y  in  9  current screen row
- game_clr  in  12  game-layer colour for (vga_x, vga_y), same cycle
- img_x  out  10  image-local column to ROM block
- img_y  out  9  image-local row to ROM block
- winner_id  out  1  latched winner to ROM block
- rom_clr  in  12  ROM block colour; valid one cycle after img_x/img_y
- pix_clr  out  12  composited pixel colour
- active  out  1  win screen in REVEAL or SHOW

Behaviour:
- Reset (async, any time, including mid-reveal):
  - state IDLE; img_x, img_y, winner_id, pix_clr, active all 0.
  - Frame/blink counters 0; blink_on 1; all pipeline valid bits 0.
- States:
  - IDLE: game_over -> REVEAL; latch winner_id <= winner_in; clear counters; blink_on <= 1. restart ignored.
  - REVEAL: each frame_tick increments frame_cnt and blink_cnt. When blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles. When frame_cnt reaches REVEAL_FRAMES-1 on a tick -> SHOW. restart -> IDLE (priority over the tick).
  - SHOW: blink_on forced 1; restart -> IDLE.
  - game_over outside IDLE is ignored; winner_id is held until the next IDLE->REVEAL transition.
- active: registered; equals (state != IDLE), so it rises the cycle after the accepting game_over edge.
- Pipeline (coordinates at cycle t):
  - Stage 1 (t+1), registered:
    - in_win = video_on & X0<=vga_x<=X0+IMG_W-1 & Y0<=vga_y<=Y0+IMG_H-1.
    - img_x = vga_x-X0 and img_y = vga_y-Y0 when in_win, else 0.
    - Register vis1 = in_win & active & blink_on; vid1 = video_on; gclr1 = game_clr.
  - Stage 2 (t+2): ROM colour is valid here. vis2, vid2, gclr2 delayed one more cycle.
  - Stage 3 (t+3), registered pix_clr:
    - 0 if !vid2;
    - else rom_clr if vis2 & rom_clr != KEY_CLR;
    - else gclr2.
  - Fixed latency 3 cycles from vga_x/vga_y/game_clr to pix_clr.
- Width rules: subtractions are unsigned and are used only when in_win, so there is no underflow. img_y*IMG_W+img_x must stay below IMG_W*IMG_H (max 14999).
- State changes mid-frame take effect per pixel at stage 1; no frame-boundary deferral.

Test Plan:
- Reset then IDLE, scan (300,200) with game_clr=12'h123 -> pix_clr=12'h123 at t+3; active=0; img_x=img_y=0.
- game_over with winner_in=1 -> active=1 next cycle, winner_id=1. Scan (245,190) -> img_x=0, img_y=0. Scan (394,289) -> img_x=149, img_y=99. Scan (395,289) and (244,190) -> img_x=img_y=0 and pix_clr=game_clr.
- In SHOW, rom_clr=12'hF0F at a window pixel -> pix_clr=game_clr; rom_clr=12'hABC -> pix_clr=12'hABC; video_on=0 -> pix_clr=0.
- BLINK_FRAMES=2, REVEAL_FRAMES=8, 8 frame_ticks:
  - window visible for ticks 0-1, hidden for 2-3, visible 4-5, hidden 6-7;
  - state SHOW after the 8th tick.
- game_over with winner_in=0 during SHOW -> winner_id stays 1. restart -> IDLE, active=0 next cycle. Next game_over with winner_in=0 -> winner_id=0.
- rst asserted mid-REVEAL, asynchronous to clk -> all outputs 0 immediately. After release, same-cycle game_over+restart in IDLE -> REVEAL.
